dac_spi_rx: RTL

- Receiver and checker for the serial stream the DAC output block drives on DAC_SYNC/DAC_SCLK/DAC_DIN.
- Deserializes each SYNC-framed word into command and data fields and checks frame length.
- Buffers decoded words in a small FIFO with a valid/ready handshake.
- Used as an on-chip loopback monitor and as the bench-side decoder for the HPF/threshold datapath, so DAC_register contents can be checked against what actually went out on the wire.

---
 rtl/dac_spi_pkg.sv | 18 +
 rtl/dac_spi_rx_if.sv | 28 ++
 rtl/dac_rx_fifo.sv | 43 ++++
 rtl/dac_spi_rx.sv | 111 +++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types and defaults for the DAC serial-stream receiver.
package dac_spi_pkg;

  localparam int unsigned DefFrameBits = 24;
  localparam int unsigned DefDataBits  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CLOSE = 2'd2
  } state_e;

  function automatic int unsigned cmd_bits(input int unsigned frame_bits,
                                           input int unsigned data_bits);
    return frame_bits - data_bits;
  endfunction

endpackage

// File: rtl/dac_spi_rx_if.sv
// Decoded-word stream: show-ahead head word with valid/ready pop handshake.
interface dac_spi_rx_if
  import dac_spi_pkg::*;
#(
  parameter int unsigned CmdBits  = cmd_bits(DefFrameBits, DefDataBits),
  parameter int unsigned DataBits = DefDataBits
);

  logic [CmdBits-1:0]  rx_cmd;
  logic [DataBits-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ready;

  modport master (
    output rx_cmd,
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_cmd,
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface

// File: rtl/dac_rx_fifo.sv
// Synchronous show-ahead FIFO; a push on a full FIFO is accepted only alongside a pop.
module dac_rx_fifo #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rd_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wptr_q, rptr_q;
  logic             do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign do_rd   = rd_i & ~empty_o;
  assign do_wr   = wr_i & (~full_o | do_rd);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[Aw-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + {{Aw{1'b0}}, 1'b1};
      if (do_rd) rptr_q <= rptr_q + {{Aw{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dac_spi_rx.sv
// Deserializes SYNC-framed DAC words, checks frame length and buffers good words.
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter int unsigned FRAME_BITS = DefFrameBits,
  parameter int unsigned DATA_BITS  = DefDataBits,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                dataclk,
  input  logic                reset,
  input  logic                DAC_SYNC,
  input  logic                DAC_SCLK,
  input  logic                DAC_DIN,
  dac_spi_rx_if.master        rx,
  output logic                err_short,
  output logic                err_long,
  output logic                overflow,
  output logic [15:0]         frame_count
);

  localparam int unsigned CntW = $clog2(FRAME_BITS + 2);
  localparam logic [CntW-1:0] FrameCnt = CntW'(FRAME_BITS);
  localparam logic [CntW-1:0] SatCnt   = CntW'(FRAME_BITS + 1);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  sync_q, sclk_q;
  logic                  overflow_q;
  logic [15:0]           frame_count_q;

  logic sync_fall, sync_rise, sclk_fall;
  logic push, pop, fifo_full, fifo_empty;
  logic [FRAME_BITS-1:0] head;

  assign sync_fall = sync_q & ~DAC_SYNC;
  assign sync_rise = ~sync_q & DAC_SYNC;
  assign sclk_fall = sclk_q & ~DAC_SCLK;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sync_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A SCLK fall coinciding with the SYNC rise belongs to no frame.
        if (sync_rise) begin
          state_d = ST_CLOSE;
        end else if (sclk_fall) begin
          if (cnt_q < FrameCnt) shift_d = {shift_q[FRAME_BITS-2:0], DAC_DIN};
          if (cnt_q < SatCnt)   cnt_d   = cnt_q + CntW'(1);
        end
      end
      ST_CLOSE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      sync_q        <= 1'b1;
      sclk_q        <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sync_q  <= DAC_SYNC;
      sclk_q  <= DAC_SCLK;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
      if (push && (!fifo_full || pop)) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign push      = (state_q == ST_CLOSE) && (cnt_q == FrameCnt);
  assign err_short = (state_q == ST_CLOSE) && (cnt_q < FrameCnt);
  assign err_long  = (state_q == ST_CLOSE) && (cnt_q > FrameCnt);
  assign pop       = rx.rx_ready & ~fifo_empty;

  dac_rx_fifo #(
    .Width (FRAME_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (dataclk),
    .rst_i   (reset),
    .wr_i    (push),
    .wdata_i (shift_q),
    .rd_i    (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx.rx_valid = ~fifo_empty;
  assign rx.rx_cmd   = head[FRAME_BITS-1:DATA_BITS];
  assign rx.rx_data  = head[DATA_BITS-1:0];
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule
